// File: rtl/aes_block_serializer.sv
// Buffers 128-bit AES ciphertext blocks in a small FIFO and streams each one out as four
// 32-bit words, MSW first. Optional macro AES_SER_LAST_EN adds a word_last output.
module aes_block_serializer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [127:0]             blk_in,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    output logic [31:0]              word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
`ifdef AES_SER_LAST_EN
    output logic                     word_last,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [127:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [1:0]    r_idx;
    logic          r_ovf;

    logic          w_push;
    logic          w_adv;
    logic          w_pop;
    logic          w_drop;
    logic [127:0]  w_head;

    function automatic logic [31:0] f_sel_word(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    assign word_valid = (r_cnt != '0);
    assign blk_ready  = (r_cnt != CNT_FULL);
    assign level      = r_cnt;
    assign ovf        = r_ovf;

    // Full state refuses new blocks even when the head pops this cycle: no bypass path.
    assign w_push = blk_valid && blk_ready;
    assign w_drop = blk_valid && !blk_ready;
    assign w_adv  = word_valid && word_ready;
    assign w_pop  = w_adv && (r_idx == 2'd3);

    assign w_head   = r_mem[r_rp];
    assign word_out = word_valid ? f_sel_word(w_head, r_idx) : 32'h0;

`ifdef AES_SER_LAST_EN
    assign word_last = word_valid && (r_idx == 2'd3);
`endif

    // Block storage carries no reset; r_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= blk_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_idx <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end
            if (w_adv) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer (DEPTH=2): a vector table for streaming and
// overflow, plus hand-written stall, full-with-pop and async-reset sequences.
module tb_aes_block_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] blk_in;
    logic         blk_valid;
    logic         blk_ready;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic [1:0]   level;
    logic         ovf;
`ifdef AES_SER_LAST_EN
    logic         word_last;
`endif

    int n_chk = 0;
    int n_err = 0;

    aes_block_serializer #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blk_in     (blk_in),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
`ifdef AES_SER_LAST_EN
        .word_last  (word_last),
`endif
        .level      (level),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         bv;
        logic [127:0] blk;
        logic         wr;
        logic         e_wv;
        logic [31:0]  e_wo;
        logic         e_br;
        logic [1:0]   e_lvl;
        logic         e_ovf;
        logic         e_last;
    } vec_t;

    localparam logic [127:0] A = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] B = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] C = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    localparam logic [127:0] D = 128'h01234567_89abcdef_fedcba98_76543210;

    vec_t tv[$];

    function automatic vec_t mk(input logic bv, input logic [127:0] blk, input logic wr,
                                input logic wv, input logic [31:0] wo, input logic br,
                                input logic [1:0] lvl, input logic ov, input logic last);
        vec_t v;
        v.bv = bv; v.blk = blk; v.wr = wr;
        v.e_wv = wv; v.e_wo = wo; v.e_br = br; v.e_lvl = lvl; v.e_ovf = ov; v.e_last = last;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, " word_valid"}, {31'd0, word_valid}, {31'd0, v.e_wv});
        chk({tag, " word_out"},   word_out, v.e_wo);
        chk({tag, " blk_ready"},  {31'd0, blk_ready}, {31'd0, v.e_br});
        chk({tag, " level"},      {30'd0, level}, {30'd0, v.e_lvl});
        chk({tag, " ovf"},        {31'd0, ovf}, {31'd0, v.e_ovf});
`ifdef AES_SER_LAST_EN
        chk({tag, " word_last"},  {31'd0, word_last}, {31'd0, v.e_last});
`endif
    endtask

    // Drive one cycle's inputs after the falling edge, then check pre-edge outputs.
    task automatic run(input string tag, input vec_t v);
        @(negedge clk);
        blk_valid  = v.bv;
        blk_in     = v.blk;
        word_ready = v.wr;
        #1;
        chk_outs(tag, v);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        blk_valid = 1'b0; blk_in = '0; word_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        blk_valid = 1'b0; blk_in = '0; word_ready = 1'b0;
        #1;
        chk("reset word_valid", {31'd0, word_valid}, 32'd0);
        chk("reset word_out",   word_out, 32'd0);
        chk("reset blk_ready",  {31'd0, blk_ready}, 32'd1);
        chk("reset level",      {30'd0, level}, 32'd0);
        chk("reset ovf",        {31'd0, ovf}, 32'd0);
        do_reset();

        // Single block, then two stored + one dropped, drained back to back.
        tv.push_back(mk(1, A, 1, 0, 32'h0,        1, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h69c4e0d8, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h6a7b0430, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'hd8cdb780, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h70b4c55a, 1, 1, 0, 1));
        tv.push_back(mk(1, B, 0, 0, 32'h0,        1, 0, 0, 0));
        tv.push_back(mk(1, C, 0, 1, 32'h00112233, 1, 1, 0, 0));
        tv.push_back(mk(1, D, 0, 1, 32'h00112233, 0, 2, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h00112233, 0, 2, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h44556677, 0, 2, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h8899aabb, 0, 2, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'hccddeeff, 0, 2, 1, 1));
        tv.push_back(mk(0, 0, 1, 1, 32'h3925841d, 1, 1, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h02dc09fb, 1, 1, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'hdc118597, 1, 1, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h196a0b32, 1, 1, 1, 1));
        tv.push_back(mk(0, 0, 1, 0, 32'h0,        1, 0, 1, 0));
        for (int i = 0; i < tv.size(); i++) begin
            run($sformatf("tbl%0d", i), tv[i]);
        end

        // Stall on word 2 for five cycles; the word must hold.
        do_reset();
        run("stall push",  mk(1, A, 1, 0, 32'h0,        1, 0, 0, 0));
        run("stall w0",    mk(0, 0, 1, 1, 32'h69c4e0d8, 1, 1, 0, 0));
        run("stall w1",    mk(0, 0, 1, 1, 32'h6a7b0430, 1, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            run($sformatf("stall hold%0d", i), mk(0, 0, 0, 1, 32'hd8cdb780, 1, 1, 0, 0));
        end
        run("stall w2",    mk(0, 0, 1, 1, 32'hd8cdb780, 1, 1, 0, 0));
        run("stall w3",    mk(0, 0, 1, 1, 32'h70b4c55a, 1, 1, 0, 1));
        run("stall empty", mk(0, 0, 0, 0, 32'h0,        1, 0, 0, 0));

        // Full FIFO with a head pop in the same cycle as a new block: block refused.
        run("full pushB",  mk(1, B, 0, 0, 32'h0,        1, 0, 0, 0));
        run("full pushC",  mk(1, C, 0, 1, 32'h00112233, 1, 1, 0, 0));
        run("full w0",     mk(0, 0, 1, 1, 32'h00112233, 0, 2, 0, 0));
        run("full w1",     mk(0, 0, 1, 1, 32'h44556677, 0, 2, 0, 0));
        run("full w2",     mk(0, 0, 1, 1, 32'h8899aabb, 0, 2, 0, 0));
        run("full popD",   mk(1, D, 1, 1, 32'hccddeeff, 0, 2, 0, 1));
        run("full c0",     mk(0, 0, 1, 1, 32'h3925841d, 1, 1, 1, 0));
        run("full c1",     mk(0, 0, 1, 1, 32'h02dc09fb, 1, 1, 1, 0));
        run("full c2",     mk(0, 0, 1, 1, 32'hdc118597, 1, 1, 1, 0));
        run("full c3",     mk(0, 0, 1, 1, 32'h196a0b32, 1, 1, 1, 1));
        run("full empty",  mk(0, 0, 0, 0, 32'h0,        1, 0, 1, 0));

        // Asynchronous reset in the middle of a partially drained block.
        run("arst push",   mk(1, A, 1, 0, 32'h0,        1, 0, 1, 0));
        run("arst w0",     mk(0, 0, 1, 1, 32'h69c4e0d8, 1, 1, 1, 0));
        run("arst w1",     mk(0, 0, 0, 1, 32'h6a7b0430, 1, 1, 1, 0));
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs("arst mid", mk(0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        run("arst pushB",  mk(1, B, 1, 0, 32'h0,        1, 0, 0, 0));
        run("arst b0",     mk(0, 0, 1, 1, 32'h00112233, 1, 1, 0, 0));
        run("arst b1",     mk(0, 0, 1, 1, 32'h44556677, 1, 1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
